// File: rtl/multicycle_mem_ctrl.sv
// Memory-side stage between the multi-cycle control FSM and a
// variable-latency unified instruction/data memory.
//
// Each memory intent from the FSM (fetch, load, store) becomes one
// req/ack transaction. The FSM is frozen with stall until the
// transaction completes. Every transaction is bounded by a timeout,
// and an expired timeout raises a sticky bus error.
//
// Parameters:
//   TIMEOUT      max ACCESS cycles waiting for mem_ack (0 = no limit)
//   RESET_INSTR  instr reset value and value captured on a fetch timeout
//   ERR_DATA     data_reg value captured on a load timeout
//
// Ports:
//   clk, rst      clock (rising edge), async active-high reset
//   cpu_req       FSM is in a memory state; held while stall=1
//   cpu_we        1 = store, 0 = read
//   cpu_ir_write  read is an instruction fetch
//   cpu_adr       byte address (bits [1:0] ignored)
//   cpu_wdata     store data
//   err_clr       synchronous clear of bus_err
//   stall         freeze FSM state and PC update
//   instr         instruction register
//   data_reg      load data register
//   bus_err       sticky timeout flag
//   mem_req       registered memory request
//   mem_we        registered memory write enable
//   mem_adr       registered word-aligned address
//   mem_wdata     registered write data
//   mem_rdata     read data, valid with mem_ack
//   mem_ack       one-cycle completion pulse

module multicycle_mem_ctrl #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [31:0] RESET_INSTR = 32'h00000013,
    parameter logic [31:0] ERR_DATA    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_ir_write,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    input  logic        err_clr,
    output logic        stall,
    output logic [31:0] instr,
    output logic [31:0] data_reg,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          ir_flag;
    logic [CW-1:0] cnt;
    logic          timeout_hit;

    // Byte offset within the word is deliberately dropped.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^cpu_adr[1:0];

    // An ack in the expiry cycle takes priority over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST) && !mem_ack;

    assign stall = ((state == S_IDLE) && cpu_req) || (state == S_ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ir_flag   <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= 32'h0;
            mem_wdata <= 32'h0;
            instr     <= RESET_INSTR;
            data_reg  <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            // Clear first so a same-cycle timeout below overrides it.
            if (err_clr) begin
                bus_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        mem_adr   <= {cpu_adr[31:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        mem_we    <= cpu_we;
                        ir_flag   <= cpu_ir_write & ~cpu_we;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            if (ir_flag) begin
                                instr <= mem_rdata;
                            end else begin
                                data_reg <= mem_rdata;
                            end
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_RESP;
                    end else if (timeout_hit) begin
                        if (!mem_we) begin
                            if (ir_flag) begin
                                instr <= RESET_INSTR;
                            end else begin
                                data_reg <= ERR_DATA;
                            end
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mem_ctrl.sv
// Scoreboard testbench for multicycle_mem_ctrl.
// Directed transactions push expectations; a monitor checks each response.

module tb_multicycle_mem_ctrl;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_ir_write = 1'b0;
    logic [31:0] cpu_adr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        err_clr = 1'b0;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] data_reg;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    multicycle_mem_ctrl #(
        .TIMEOUT    (TO),
        .RESET_INSTR(32'h00000013),
        .ERR_DATA   (32'h00000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_ir_write(cpu_ir_write),
        .cpu_adr     (cpu_adr),
        .cpu_wdata   (cpu_wdata),
        .err_clr     (err_clr),
        .stall       (stall),
        .instr       (instr),
        .data_reg    (data_reg),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        we;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int resps  = 0;

    logic [31:0] m_instr = 32'h00000013;
    logic [31:0] m_data  = 32'h0;
    logic        m_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is the cycle where stall falls after being high.
    initial begin
        logic        prev_stall = 1'b0;
        int          scnt = 0;
        logic        have = 1'b0;
        logic        moved = 1'b0;
        logic [31:0] s_adr = 32'h0;
        logic [31:0] s_wd = 32'h0;
        logic        s_we = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                scnt = 0;
                have = 1'b0;
                moved = 1'b0;
            end else begin
                if (stall) scnt++;
                if (mem_req) begin
                    if (!have) begin
                        s_adr = mem_adr;
                        s_wd  = mem_wdata;
                        s_we  = mem_we;
                        have  = 1'b1;
                    end else if (mem_adr !== s_adr || mem_wdata !== s_wd ||
                                 mem_we !== s_we) begin
                        moved = 1'b1;
                    end
                end
                if (prev_stall && !stall) begin
                    resps++;
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("instr", instr, e.instr);
                        chk("data_reg", data_reg, e.data);
                        chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                        chk("stall_cycles", scnt, e.stalls);
                        chk("mem_adr", s_adr, e.adr);
                        chk("mem_we_access", {31'd0, s_we}, {31'd0, e.we});
                        if (e.we) chk("mem_wdata", s_wd, e.wdata);
                        chk("mem_stable", {31'd0, moved}, 32'd0);
                        chk("resp_mem_req", {31'd0, mem_req}, 32'd0);
                        chk("resp_mem_we", {31'd0, mem_we}, 32'd0);
                    end
                    scnt = 0;
                    have = 1'b0;
                    moved = 1'b0;
                end
                prev_stall = stall;
            end
        end
    end

    // n = ACCESS cycles; ack on the n-th when ack=1, otherwise timeout.
    task automatic txn(input logic we, input logic ir,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] rd, input int n, input bit ack,
                       input bit clr_last, input bit late);
        exp_t e;
        if (ack) begin
            if (!we) begin
                if (ir) m_instr = rd;
                else m_data = rd;
            end
            if (clr_last) m_err = 1'b0;
        end else begin
            m_err = 1'b1;
            if (!we) begin
                if (ir) m_instr = 32'h00000013;
                else m_data = 32'h0;
            end
        end
        e.instr  = m_instr;
        e.data   = m_data;
        e.adr    = {adr[31:2], 2'b00};
        e.wdata  = wd;
        e.we     = we;
        e.err    = m_err;
        e.stalls = n + 1;
        sb.push_back(e);

        cpu_req = 1'b1;
        cpu_we = we;
        cpu_ir_write = ir;
        cpu_adr = adr;
        cpu_wdata = wd;
        @(posedge clk); #1;
        for (int i = 1; i <= n; i++) begin
            if (i == n) begin
                mem_ack = ack;
                mem_rdata = rd;
                err_clr = clr_last;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            err_clr = 1'b0;
        end
        cpu_req = 1'b0;
        if (late) begin
            mem_ack = 1'b1;
            mem_rdata = 32'h0BADC0DE;
            @(posedge clk); #1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            chk("late_ack_req", {31'd0, mem_req}, 32'd0);
            chk("late_ack_stall", {31'd0, stall}, 32'd0);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clr", {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_instr", instr, 32'h00000013);
        chk("rst_data", data_reg, 32'h0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 32'h00000010, 32'h0, 32'h00500093, 1, 1'b1, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 32'h00000103, 32'h0, 32'hDEADBEEF, 5, 1'b1, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 32'h00000020, 32'h12345678, 32'hBAD0BAD0, 2, 1'b1,
            1'b0, 1'b0);
        txn(1'b0, 1'b0, 32'h00000044, 32'h0, 32'hCAFEF00D, TO, 1'b1, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 32'h00000008, 32'h0, 32'h0, TO, 1'b0, 1'b0, 1'b1);
        txn(1'b0, 1'b0, 32'h00000030, 32'h0, 32'h11112222, 2, 1'b1, 1'b0, 1'b0);
        clear_err();
        txn(1'b0, 1'b0, 32'h00000034, 32'h0, 32'h0, TO, 1'b0, 1'b1, 1'b0);
        clear_err();

        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_ir_write = 1'b1;
        cpu_adr = 32'h00000040;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_instr", instr, 32'h00000013);
        chk("mid_rst_data", data_reg, 32'h0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_instr = 32'h00000013;
        m_data = 32'h0;
        m_err = 1'b0;
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 32'h00000046, 32'h0, 32'h00A00113, 3, 1'b1, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        chk("resp_count", resps, 32'd8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_mem_ctrl.md
Name: multicycle_mem_ctrl

Overview:
- Memory-side stage directly downstream of the multi-cycle control FSM and datapath address mux.
- Turns the FSM's single-cycle memory intents (instruction fetch, load, store) into a req/ack transaction on a variable-latency unified instruction/data memory.
- Freezes the FSM with `stall` until each transaction completes.
- Owns the instruction register and the load data register, so the FSM sees stable values after each access.
- Bounds every transaction with a timeout and reports a sticky bus error.

Parameters:
- `TIMEOUT`, 16: max cycles in ACCESS waiting for `mem_ack`; 0 disables the timeout.
- `RESET_INSTR`, 32'h00000013: instruction register reset value and value captured on a timed-out fetch (`addi x0,x0,0`).
- `ERR_DATA`, 32'h00000000: value captured into `data_reg` on a timed-out load.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  FSM is in a memory state (Fetch, MemRead, MemWrite); held high while `stall`=1.
- `cpu_we`  in  1  store when 1, read when 0.
- `cpu_ir_write`  in  1  read is an instruction fetch; capture into `instr`.
- `cpu_adr`  in  32  byte address from the datapath address mux.
- `cpu_wdata`  in  32  store data.
- `err_clr`  in  1  synchronous clear of `bus_err`.
- `stall`  out  1  freeze FSM state and PC update.
- `instr`  out  32  instruction register.
- `data_reg`  out  32  load data register.
- `bus_err`  out  1  sticky timeout flag.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  memory write enable, registered.
- `mem_adr`  out  32  word-aligned address, registered.
- `mem_wdata`  out  32  write data, registered.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate): state=IDLE; `mem_req`=0; `mem_we`=0; `mem_adr`=0; `mem_wdata`=0; `instr`=`RESET_INSTR`; `data_reg`=0; `bus_err`=0; timeout counter=0.
  - Reset asserted mid-ACCESS drops `mem_req` immediately and abandons the transaction.
- States: IDLE, ACCESS, RESP.
- `stall` (combinational) = (IDLE & `cpu_req`) | ACCESS. It is 0 in RESP and in IDLE without a request.
- IDLE:
  - If `cpu_req`=1, register the following, then go to ACCESS: `mem_adr`={`cpu_adr`[31:2],2'b00}; `mem_wdata`=`cpu_wdata`; `mem_we`=`cpu_we`; an internal ir flag=`cpu_ir_write`&~`cpu_we`; `mem_req`=1; counter=0.
  - `mem_ack` in IDLE is ignored.
- ACCESS:
  - `mem_req`, `mem_we`, `mem_adr` and `mem_wdata` are held stable.
  - On `mem_ack`=1 with a read and ir flag=1: `instr`<=`mem_rdata`.
  - On `mem_ack`=1 with a read and ir flag=0: `data_reg`<=`mem_rdata`.
  - On `mem_ack`=1 with a write: no capture.
  - On any `mem_ack`: `mem_req`<=0, `mem_we`<=0, go to RESP.
  - Acknowledge in the first ACCESS cycle is legal.
  - Timeout: counter increments each ACCESS cycle without ack. When `TIMEOUT`≠0 and counter==`TIMEOUT`-1 with no ack:
    - `mem_req`<=0 and `mem_we`<=0.
    - `bus_err`<=1.
    - On a fetch, `instr`<=`RESET_INSTR`; on a load, `data_reg`<=`ERR_DATA`; on a store, nothing is written.
    - Go to RESP.
  - Ack arriving in the same cycle as the timeout wins: normal capture, no error.
- RESP:
  - Single cycle; `stall`=0, so the FSM advances on this edge. Always go to IDLE.
  - `cpu_req` in RESP is ignored; a new access requires `cpu_req` high in IDLE.
  - `mem_ack` in RESP is ignored (late ack after timeout).
- Latency:
  - Request to release = 2 + (ACCESS cycles). Minimum 3 cycles, with `stall` high for 2 of them.
  - `instr`/`data_reg` are valid from the RESP cycle on and hold until the next capture.
- `bus_err`:
  - Set by timeout; cleared only by `rst` or `err_clr` (synchronous).
  - `err_clr` and timeout in the same cycle: set wins.
- Unused `cpu_adr`[1:0] is ignored; misalignment is not flagged.
- `mem_*` outputs are updated only on state transitions, never combinationally from `cpu_*`.

Test Plan:
- Fetch, ack in the first ACCESS cycle: `cpu_req`=1, `cpu_ir_write`=1, `cpu_adr`=32'h00000010, `mem_rdata`=32'h00500093 → `mem_adr`=0x10; `stall` high 2 cycles; `instr`=32'h00500093 in RESP; `data_reg` unchanged.
- Load, 5 wait cycles: `cpu_adr`=32'h00000103, ack on the 5th ACCESS cycle with `mem_rdata`=32'hDEADBEEF → `mem_adr`=0x100 and stable for 5 cycles; `stall` high 6 cycles; `data_reg`=32'hDEADBEEF; `instr` unchanged.
- Store: `cpu_we`=1, `cpu_wdata`=32'h12345678, `cpu_adr`=0x20, ack after 2 cycles → `mem_we`=1 and `mem_wdata`=32'h12345678 during ACCESS; neither register changes; `mem_we`=0 in RESP.
- Timeout fetch, `TIMEOUT`=4, no ack → `mem_req` drops after 4 ACCESS cycles; `instr`=32'h00000013; `bus_err`=1 and stays 1 through later good accesses until `err_clr`=1 clears it next edge.
- Ack on the same cycle as timeout expiry → normal capture, `bus_err` stays 0. A late ack in RESP/IDLE → no capture, no state change.
- `rst` asserted during ACCESS → `mem_req`=0 immediately, state IDLE, `instr`=32'h00000013. After release, a new `cpu_req` starts a clean access.
